// File: rtl/ring_pkg.sv
// Shared ring definitions: slot type codes, default field widths, ADDR slot layout.
// Used by ring nodes, the ring top and the memory controller.
package ring_pkg;

  localparam int TSIZE_DEF = 4;
  localparam int SSIZE_DEF = 4;

  localparam int SLOT_NULL  = 0;
  localparam int SLOT_TOKEN = 1;
  localparam int SLOT_ADDR  = 2;
  localparam int SLOT_WDATA = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TOKEN,
    ST_SEND_WDATA,
    ST_RELEASE,
    ST_WAIT_RDATA
  } node_state_e;

  // ADDR slot payload: line address in the low bits, rw flag directly above it.
  function automatic logic [31:0] addr_slot_data(input logic rw, input logic [31:0] line,
                                                 input int nbcacheline);
    logic [31:0] mask;
    mask = (32'd1 << nbcacheline) - 32'd1;
    return (line & mask) | ({31'd0, rw} << nbcacheline);
  endfunction

endpackage

// File: rtl/ring_line_buf.sv
// Read-line assembly buffer: one 32-bit word written per cycle by index,
// whole line visible as a flat vector.
module ring_line_buf #(
  parameter int NBWORDS = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [NBWORDS-1:0]           wr_idx,
  input  logic [31:0]                  wr_data,
  output logic [(32<<NBWORDS)-1:0]     line_out
);

  logic [(32<<NBWORDS)-1:0] line_q, line_d;

  always_comb begin
    line_d = line_q;
    if (wr_en) begin
      line_d[{wr_idx, 5'd0} +: 32] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign line_out = line_q;

endmodule

// File: rtl/ring_node.sv
// Per-core ring stop: grabs the token, injects ADDR (+WDATA for writebacks), re-emits
// the token, strips its own returning slots and assembles read lines from the mc bus.
module ring_node
  import ring_pkg::*;
#(
  parameter int CORENUM     = 1,
  parameter int TSIZE       = TSIZE_DEF,
  parameter int SSIZE       = SSIZE_DEF,
  parameter int NBWORDS     = 3,
  parameter int NBCACHELINE = 30 - NBWORDS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [TSIZE-1:0]           slot_type_in,
  input  logic [SSIZE-1:0]           slot_source_in,
  input  logic [31:0]                slot_data_in,
  output logic [TSIZE-1:0]           slot_type_out,
  output logic [SSIZE-1:0]           slot_source_out,
  output logic [31:0]                slot_data_out,
  input  logic [SSIZE-1:0]           mc_dest,
  input  logic [NBWORDS-1:0]         mc_count,
  input  logic [31:0]                mc_data,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [NBCACHELINE-1:0]     req_line,
  input  logic [(32<<NBWORDS)-1:0]   req_wdata,
  output logic                       rsp_valid,
  output logic [(32<<NBWORDS)-1:0]   rsp_rdata,
  output logic                       wr_done,
  output logic                       proto_err
);

  localparam logic [NBWORDS-1:0] CNT_LAST = {NBWORDS{1'b1}};
  localparam logic [TSIZE-1:0]   T_NULL   = TSIZE'(SLOT_NULL);
  localparam logic [TSIZE-1:0]   T_TOKEN  = TSIZE'(SLOT_TOKEN);
  localparam logic [TSIZE-1:0]   T_ADDR   = TSIZE'(SLOT_ADDR);
  localparam logic [TSIZE-1:0]   T_WDATA  = TSIZE'(SLOT_WDATA);
  localparam logic [SSIZE-1:0]   MY_ID    = SSIZE'(CORENUM);

  node_state_e                  state_q, state_d;
  logic                         write_q, write_d;
  logic [NBCACHELINE-1:0]       line_q, line_d;
  logic [(32<<NBWORDS)-1:0]     wdata_q, wdata_d;
  logic [NBWORDS-1:0]           cnt_q, cnt_d;
  logic                         rsp_valid_q, rsp_valid_d;
  logic                         wr_done_q, wr_done_d;
  logic                         proto_err_q, proto_err_d;

  logic own_slot;
  logic held_slot_ok;
  logic mc_hit;

  assign own_slot     = ((slot_type_in == T_ADDR) || (slot_type_in == T_WDATA)) &&
                        (slot_source_in == MY_ID);
  // While we own the token, whatever we overwrite must be empty or our own echo.
  assign held_slot_ok = (slot_type_in == T_NULL) || own_slot;
  assign mc_hit       = (mc_dest == MY_ID);

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    line_d      = line_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    wr_done_d   = 1'b0;
    proto_err_d = proto_err_q;

    slot_type_out   = slot_type_in;
    slot_source_out = slot_source_in;
    slot_data_out   = slot_data_in;
    if (own_slot) begin
      slot_type_out   = T_NULL;
      slot_source_out = '0;
      slot_data_out   = '0;
    end

    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            write_d = req_write;
            line_d  = req_line;
            wdata_d = req_wdata;
            state_d = ST_WAIT_TOKEN;
          end
        end
        ST_WAIT_TOKEN: begin
          if (slot_type_in == T_TOKEN) begin
            slot_type_out   = T_ADDR;
            slot_source_out = MY_ID;
            slot_data_out   = addr_slot_data(write_q, 32'(line_q), NBCACHELINE);
            cnt_d           = '0;
            state_d         = write_q ? ST_SEND_WDATA : ST_RELEASE;
          end
        end
        ST_SEND_WDATA: begin
          slot_type_out   = T_WDATA;
          slot_source_out = MY_ID;
          slot_data_out   = wdata_q[{cnt_q, 5'd0} +: 32];
          if (!held_slot_ok) proto_err_d = 1'b1;
          cnt_d = cnt_q + NBWORDS'(1);
          if (cnt_q == CNT_LAST) state_d = ST_RELEASE;
        end
        ST_RELEASE: begin
          slot_type_out   = T_TOKEN;
          slot_source_out = '0;
          slot_data_out   = '0;
          if (!held_slot_ok) proto_err_d = 1'b1;
          if (write_q) begin
            wr_done_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_WAIT_RDATA;
          end
        end
        ST_WAIT_RDATA: begin
          if (mc_hit && (mc_count == CNT_LAST)) begin
            rsp_valid_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (mc_hit && (state_q != ST_WAIT_RDATA) && (state_q != ST_RELEASE)) begin
        proto_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      line_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      wr_done_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      line_q      <= line_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      wr_done_q   <= wr_done_d;
      proto_err_q <= proto_err_d;
    end
  end

  ring_line_buf #(.NBWORDS(NBWORDS)) u_line_buf (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (mc_hit),
    .wr_idx   (mc_count),
    .wr_data  (mc_data),
    .line_out (rsp_rdata)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign wr_done   = wr_done_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_ring_node.sv
// Directed bench for ring_node (CORENUM=1, 8-word lines): strip/pass, read, write,
// protocol errors, mid-write reset and back-to-back reads.
module tb_ring_node;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   slot_type_in, slot_type_out;
  logic [3:0]   slot_source_in, slot_source_out;
  logic [31:0]  slot_data_in, slot_data_out;
  logic [3:0]   mc_dest;
  logic [2:0]   mc_count;
  logic [31:0]  mc_data;
  logic         req_valid, req_ready, req_write;
  logic [26:0]  req_line;
  logic [255:0] req_wdata;
  logic         rsp_valid;
  logic [255:0] rsp_rdata;
  logic         wr_done, proto_err;

  logic [39:0]  slot_o;
  logic [255:0] exp_line;
  logic [255:0] wline;
  int checks = 0;
  int errors = 0;

  assign slot_o = {slot_type_out, slot_source_out, slot_data_out};

  ring_node #(.CORENUM(1)) dut (
    .clk(clk), .reset(reset),
    .slot_type_in(slot_type_in), .slot_source_in(slot_source_in), .slot_data_in(slot_data_in),
    .slot_type_out(slot_type_out), .slot_source_out(slot_source_out), .slot_data_out(slot_data_out),
    .mc_dest(mc_dest), .mc_count(mc_count), .mc_data(mc_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_line(req_line), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .wr_done(wr_done), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] slot(input int t, input int s, input logic [31:0] d);
    return {4'(t), 4'(s), d};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chks(input string tag, input logic [39:0] exp);
    checks++;
    assert (slot_o === exp) else begin
      errors++;
      $error("FAIL %s observed=%010h expected=%010h", tag, slot_o, exp);
    end
  endtask

  task automatic chkl(input string tag, input logic [255:0] exp);
    checks++;
    assert (rsp_rdata === exp) else begin
      errors++;
      $error("FAIL %s observed=%064h expected=%064h", tag, rsp_rdata, exp);
    end
  endtask

  // Inputs change just after the falling edge; checks run 1 time unit later.
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic drive_slot(input int t, input int s, input logic [31:0] d);
    slot_type_in   = 4'(t);
    slot_source_in = 4'(s);
    slot_data_in   = d;
  endtask

  task automatic do_reset();
    nxt(); reset = 1'b1;
    nxt(); reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive_slot(0, 0, 32'h0);
    mc_dest = 4'd0; mc_count = 3'd0; mc_data = 32'h0;
    req_valid = 1'b0; req_write = 1'b0; req_line = 27'h0; req_wdata = '0;
    for (int k = 0; k < 8; k++) wline[32*k +: 32] = 32'(32'h100 + k);

    // Reset state, and pass-through while reset is held
    nxt(); nxt();
    drive_slot(2, 1, 32'h55); #1;
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_wr_done", wr_done, 1'b0);
    chk1("rst_proto_err", proto_err, 1'b0);
    chkl("rst_rdata", 256'h0);
    chks("rst_strip", slot(0, 0, 32'h0));
    nxt(); reset = 1'b0; drive_slot(0, 0, 32'h0);

    // Strip / pass-through while idle
    nxt(); drive_slot(3, 2, 32'hDEAD); #1; chks("pass_wdata2", slot(3, 2, 32'hDEAD));
    nxt(); drive_slot(2, 1, 32'h55);   #1; chks("strip_addr1", slot(0, 0, 32'h0));
    nxt(); drive_slot(1, 0, 32'h0);    #1; chks("idle_token", slot(1, 0, 32'h0));

    // Read: a token in the accept cycle is not taken
    nxt(); req_valid = 1'b1; req_write = 1'b0; req_line = 27'h0000123; #1;
    chk1("rd_ready_idle", req_ready, 1'b1);
    chks("rd_accept_token_passes", slot(1, 0, 32'h0));
    nxt(); req_valid = 1'b0; drive_slot(0, 0, 32'h0); #1;
    chk1("rd_ready_busy", req_ready, 1'b0);
    nxt(); nxt(); nxt();
    drive_slot(1, 0, 32'h0); #1; chks("rd_addr", slot(2, 1, 32'h00000123));
    nxt(); drive_slot(0, 0, 32'h0); #1; chks("rd_token_out", slot(1, 0, 32'h0));
    nxt(); drive_slot(3, 2, 32'h77); #1; chks("rd_wait_pass", slot(3, 2, 32'h77));
    drive_slot(0, 0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      nxt(); mc_dest = 4'd1; mc_count = 3'(k); mc_data = 32'(32'hA0 + k);
      exp_line[32*k +: 32] = 32'(32'hA0 + k);
    end
    #1; chk1("rd_no_early_rsp", rsp_valid, 1'b0);
    nxt(); mc_dest = 4'd0; #1;
    chk1("rd_rsp_valid", rsp_valid, 1'b1);
    chkl("rd_rdata", exp_line);
    chk1("rd_ready_after", req_ready, 1'b1);
    chk1("rd_no_err", proto_err, 1'b0);
    nxt(); #1;
    chk1("rd_rsp_pulse", rsp_valid, 1'b0);
    chkl("rd_rdata_stable", exp_line);

    // Write: ADDR, 8 WDATA, TOKEN, then wr_done
    nxt(); req_valid = 1'b1; req_write = 1'b1; req_line = 27'h5; req_wdata = wline;
    nxt(); req_valid = 1'b0; drive_slot(1, 0, 32'h0); #1;
    chks("wr_addr", slot(2, 1, 32'h08000005));
    for (int k = 0; k < 8; k++) begin
      nxt(); drive_slot(0, 0, 32'h0); #1;
      chks("wr_wdata", slot(3, 1, 32'(32'h100 + k)));
    end
    chk1("wr_done_early", wr_done, 1'b0);
    nxt(); #1; chks("wr_token_out", slot(1, 0, 32'h0));
    nxt(); #1;
    chk1("wr_done", wr_done, 1'b1);
    chk1("wr_ready", req_ready, 1'b1);
    nxt(); #1;
    chk1("wr_done_pulse", wr_done, 1'b0);
    chk1("wr_no_err", proto_err, 1'b0);

    // Reset in the third WDATA cycle
    nxt(); req_valid = 1'b1; req_write = 1'b1; req_line = 27'h6;
    nxt(); req_valid = 1'b0; drive_slot(1, 0, 32'h0);
    nxt(); drive_slot(0, 0, 32'h0);
    nxt();
    nxt(); reset = 1'b1; drive_slot(3, 2, 32'hBEEF); #1;
    chks("mrst_pass", slot(3, 2, 32'hBEEF));
    nxt(); reset = 1'b0; drive_slot(0, 0, 32'h0); #1;
    chk1("mrst_ready", req_ready, 1'b1);
    chks("mrst_out_null", slot(0, 0, 32'h0));
    chk1("mrst_no_wr_done", wr_done, 1'b0);
    for (int k = 0; k < 8; k++) nxt();
    #1; chk1("mrst_no_late_wr_done", wr_done, 1'b0);

    // Fresh read after reset, words with gaps and out of order, last index last
    nxt(); req_valid = 1'b1; req_write = 1'b0; req_line = 27'h3C;
    nxt(); req_valid = 1'b0; drive_slot(1, 0, 32'h0); #1;
    chks("rd2_addr", slot(2, 1, 32'h0000003C));
    nxt(); drive_slot(0, 0, 32'h0);
    for (int k = 6; k >= 0; k--) begin
      nxt(); mc_dest = 4'd1; mc_count = 3'(k); mc_data = 32'(32'hB0 + k);
      exp_line[32*k +: 32] = 32'(32'hB0 + k);
      nxt(); mc_dest = 4'd0;
    end
    #1; chk1("rd2_not_done", rsp_valid, 1'b0);
    nxt(); mc_dest = 4'd1; mc_count = 3'd7; mc_data = 32'hB7;
    exp_line[255:224] = 32'hB7;
    nxt(); mc_dest = 4'd0; #1;
    chk1("rd2_rsp_valid", rsp_valid, 1'b1);
    chkl("rd2_rdata", exp_line);
    chk1("rd2_no_err", proto_err, 1'b0);

    // Protocol error: foreign ADDR overwritten during SEND_WDATA
    nxt(); req_valid = 1'b1; req_write = 1'b1; req_line = 27'h9; req_wdata = wline;
    nxt(); req_valid = 1'b0; drive_slot(1, 0, 32'h0);
    nxt(); drive_slot(3, 1, 32'h1234); #1; chks("pe_own_strip", slot(3, 1, 32'h100));
    nxt(); drive_slot(2, 3, 32'h77); #1;
    chk1("pe_own_no_err", proto_err, 1'b0);
    chks("pe_overwrite", slot(3, 1, 32'h101));
    nxt(); drive_slot(0, 0, 32'h0); #1;
    chk1("pe_set", proto_err, 1'b1);
    for (int k = 0; k < 7; k++) nxt();
    #1; chk1("pe_wr_done", wr_done, 1'b1);
    chk1("pe_sticky", proto_err, 1'b1);
    do_reset(); #1;
    chk1("pe_cleared", proto_err, 1'b0);

    // Protocol error: read data addressed to us while idle
    nxt(); mc_dest = 4'd1; mc_count = 3'd0; mc_data = 32'h1;
    nxt(); mc_dest = 4'd0; #1;
    chk1("pe_mc_idle", proto_err, 1'b1);
    do_reset();

    // Back-to-back reads with req_valid held high
    nxt(); req_valid = 1'b1; req_write = 1'b0; req_line = 27'h200;
    nxt(); drive_slot(1, 0, 32'h0); #1;
    chks("b2b_addr1", slot(2, 1, 32'h00000200));
    nxt(); drive_slot(0, 0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      nxt(); mc_dest = 4'd1; mc_count = 3'(k); mc_data = 32'(32'hC0 + k);
      exp_line[32*k +: 32] = 32'(32'hC0 + k);
    end
    nxt(); mc_dest = 4'd0; req_line = 27'h201; #1;
    chk1("b2b_rsp_valid", rsp_valid, 1'b1);
    chk1("b2b_ready", req_ready, 1'b1);
    chkl("b2b_rdata", exp_line);
    nxt(); req_valid = 1'b0; #1;
    chk1("b2b_accepted", req_ready, 1'b0);
    chkl("b2b_rdata_hold", exp_line);
    nxt(); nxt(); drive_slot(1, 0, 32'h0); #1;
    chks("b2b_addr2", slot(2, 1, 32'h00000201));
    nxt(); drive_slot(0, 0, 32'h0); #1;
    chks("b2b_token2", slot(1, 0, 32'h0));
    chk1("b2b_no_err", proto_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ring_node.md
Name: ring_node

Overview:
- Per-core ring interface; the stage that feeds the ring and memory controller.
- Accepts one cache-line request at a time from the core's cache.
- Waits for the circulating TOKEN and injects an ADDR slot, plus NWORDS WDATA slots for writes, then re-emits the TOKEN.
- Strips its own slots as they come back round the ring, and assembles returning read words from the pipelined mc bus into a full line.

Parameters:
- CORENUM, 1: this node's source ID; 1..(1<<SSIZE)-1. ID 0 means "no destination".
- TSIZE, 4: slot type width.
- SSIZE, 4: slot source width.
- NBWORDS, 3: log2 of words per cache line; NWORDS = 1<<NBWORDS.
- NBCACHELINE, 30-NBWORDS: cache-line address width.

Ports:
- clk  in  1  clock.
- reset  in  1  sync, active-high.
- slot_type_in / slot_source_in / slot_data_in  in  TSIZE/SSIZE/32  incoming ring slot from the upstream ring register.
- slot_type_out / slot_source_out / slot_data_out  out  TSIZE/SSIZE/32  outgoing slot. Combinational; the ring register is external.
- mc_dest / mc_count / mc_data  in  SSIZE/NBWORDS/32  read-data bus: destination, word index, word.
- req_valid  in  1  cache request valid.
- req_ready  out  1  node can accept a request.
- req_write  in  1  1 = line writeback, 0 = line fill.
- req_line  in  NBCACHELINE  cache-line address.
- req_wdata  in  32*NWORDS  write line; word k is bits [32k+31:32k].
- rsp_valid  out  1  one-cycle pulse: read line complete.
- rsp_rdata  out  32*NWORDS  assembled read line; stable from the rsp_valid pulse until the next read is accepted.
- wr_done  out  1  one-cycle pulse: all WDATA slots injected.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Slot encodings: NULL=0, TOKEN=1, ADDR=2, WDATA=3. ADDR slot data is {zeros, rw at bit NBCACHELINE, line[NBCACHELINE-1:0]}.
- Reset: state IDLE; req_ready=1; rsp_valid=0; wr_done=0; proto_err=0; rsp_rdata=0. Slot outputs follow the pass-through rule during reset.
- Pass-through rule (any state not driving the ring):
  - Incoming ADDR/WDATA with source==CORENUM → output NULL, source 0, data 0 (strip own slot).
  - Everything else is copied unchanged.
- Handshake: request accepted on req_valid && req_ready; write flag, line and wdata are latched. req_ready=1 only in IDLE.
- FSM states: IDLE, WAIT_TOKEN, SEND_WDATA, RELEASE, WAIT_RDATA.
  - IDLE: on accept → WAIT_TOKEN. A TOKEN arriving in the accept cycle is not used.
  - WAIT_TOKEN: pass-through. When slot_type_in==TOKEN, output the ADDR slot (source CORENUM) in that same cycle, consuming the token. Next state: write → SEND_WDATA with word count 0; read → RELEASE.
  - SEND_WDATA: output WDATA, source CORENUM, data = word[cnt], cnt = 0..NWORDS-1, one per cycle. After cnt==NWORDS-1 → RELEASE.
  - RELEASE: output TOKEN, source 0, data 0. Write → IDLE with wr_done=1 next cycle. Read → WAIT_RDATA.
  - WAIT_RDATA: pass-through; waits for the read data described below.
- Token latency: ADDR is driven in the token's arrival cycle. The token reappears 1 cycle later for reads, NWORDS+1 cycles later for writes.
- Incoming slots overwritten while holding the token (ADDR, SEND_WDATA, RELEASE cycles):
  - Must be NULL, or own-source ADDR/WDATA (which is thereby stripped).
  - Any other value sets proto_err. The slot is still overwritten.
- Read assembly: in any state, mc_dest==CORENUM writes mc_data into line word mc_count.
  - In WAIT_RDATA, the word with mc_count==NWORDS-1 completes the line: rsp_valid=1 next cycle, state → IDLE.
  - Words are not assumed to arrive in consecutive cycles, but each index arrives exactly once.
  - mc_dest==CORENUM outside WAIT_RDATA/RELEASE sets proto_err.
- Only one request is outstanding. A new request can be accepted in the cycle rsp_valid or wr_done is high.
- Reset mid-operation: abandon the request and return to IDLE. The ring top regenerates the token on reset; no pulses are emitted.

Decomposition:
- Package ring_pkg: slot-type constants NULL/TOKEN/ADDR/WDATA, TSIZE/SSIZE defaults, and the ADDR-slot field layout (rw bit position). Shared with the ring top and the memory controller.
- One natural sub-module: ring_line_buf, an NWORDS×32 register file with indexed write and a flat line output, used for read assembly.

Test Plan:
- Read, CORENUM=1: req line 0x0000123 → wait; TOKEN in at cycle 10.
  - Expect ADDR:1:0x00000123 at cycle 10 and TOKEN at 11.
  - Drive mc_dest=1, counts 0..7, data 0xA0..0xA7, at cycles 30..37.
  - Expect rsp_valid at cycle 38 with word k = 0xA0+k, and req_ready=1.
- Write: req_write=1, line 0x05, words 0x100+k; TOKEN in at cycle 5.
  - Expect ADDR data bit27=1, line 5 at cycle 5.
  - Expect WDATA 0x100..0x107 at cycles 6..13, TOKEN at 14, wr_done at 15.
- Strip/pass: no request. Incoming WDATA:2:0xDEAD passes unchanged. Incoming ADDR:1:0x55 leaves as NULL:0:0. TOKEN passes when idle.
- Protocol error: while in SEND_WDATA, inject incoming ADDR from source 3 → proto_err=1 and stays 1. Separately, mc_dest=1 while IDLE → proto_err=1.
- Reset: assert reset at the 3rd WDATA cycle → next cycle state IDLE, req_ready=1, outputs pass-through, no wr_done. A fresh read then completes normally.
- Back-to-back: hold req_valid continuously. A second read is accepted in the rsp_valid cycle and its ADDR is sent on the next token arrival.
